// File: rtl/hazard_unit.sv
// Pipeline hazard unit: branch flush, multicycle EX freeze, RAW stall, perf counters.
// Optional macro HAZARD_FORWARDING_EN: RAW stall only on load-use (EX forwards the rest).
module hazard_unit #(
  parameter int REG_ADDR_W  = 5,
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] in_IFID_rs1,
  input  logic [REG_ADDR_W-1:0] in_IFID_rs2,
  input  logic                  in_IFID_uses_rs1,
  input  logic                  in_IFID_uses_rs2,
  input  logic [REG_ADDR_W-1:0] in_IDEX_rd,
  input  logic [REG_ADDR_W-1:0] in_EXMEM_rd,
  input  logic [REG_ADDR_W-1:0] in_MEMWB_rd,
  input  logic                  in_IDEX_write_enable,
  input  logic                  in_EXMEM_write_enable,
  input  logic                  in_MEMWB_write_enable,
  input  logic                  in_IDEX_mem_read,
  input  logic                  in_IDEX_multicycle,
  input  logic                  in_EXMEM_branch_taken,
  output logic                  out_stall_PC,
  output logic                  out_stall_IFID,
  output logic                  out_stall_IDEX,
  output logic                  out_flush_IFID,
  output logic                  out_flush_IDEX,
  output logic                  out_flush_EXMEM,
  output logic [CNT_W-1:0]      out_stall_cycles,
  output logic [CNT_W-1:0]      out_flush_events
);

  typedef enum logic [0:0] {RUN = 1'b0, BUSY = 1'b1} state_t;

  // The RUN cycle that launches the op is the first stall cycle, hence the -2.
  localparam logic [3:0]       BUSY_LOAD = 4'(MUL_LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_next_s;
  logic       idex_hit_s;
  logic       exmem_hit_s;
  logic       memwb_hit_s;
  logic       load_use_s;
  logic       raw_s;
  logic       branch_s;
  logic       mc_stall_s;
  logic       raw_stall_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] flush_events_r;

  function automatic logic rd_matches(input logic [REG_ADDR_W-1:0] rd,
                                      input logic                  we);
    logic hit1;
    logic hit2;
    hit1 = in_IFID_uses_rs1 && (rd == in_IFID_rs1);
    hit2 = in_IFID_uses_rs2 && (rd == in_IFID_rs2);
    return we && (rd != {REG_ADDR_W{1'b0}}) && (hit1 || hit2);
  endfunction

  assign idex_hit_s  = rd_matches(in_IDEX_rd,  in_IDEX_write_enable);
  assign exmem_hit_s = rd_matches(in_EXMEM_rd, in_EXMEM_write_enable);
  assign memwb_hit_s = rd_matches(in_MEMWB_rd, in_MEMWB_write_enable);
  assign load_use_s  = idex_hit_s && in_IDEX_mem_read;

`ifdef HAZARD_FORWARDING_EN
  assign raw_s = load_use_s;
`else
  // No forwarding and no register-file write-through: any in-flight producer blocks decode.
  assign raw_s = load_use_s || idex_hit_s || exmem_hit_s || memwb_hit_s;
`endif

  // State and multicycle countdown register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic; a taken branch abandons any multicycle op in flight.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    if (in_EXMEM_branch_taken) begin
      state_next_s = RUN;
      cnt_next_s   = 4'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (in_IDEX_multicycle) begin
            state_next_s = BUSY;
            cnt_next_s   = BUSY_LOAD;
          end else begin
            state_next_s = RUN;
            cnt_next_s   = 4'd0;
          end
        end
        BUSY: begin
          if (cnt_r != 4'd0) begin
            cnt_next_s = cnt_r - 4'd1;
          end else begin
            state_next_s = RUN;
          end
        end
        default: begin
          state_next_s = RUN;
          cnt_next_s   = 4'd0;
        end
      endcase
    end
  end

  assign branch_s    = in_EXMEM_branch_taken;
  assign mc_stall_s  = !branch_s && (((state_r == RUN) && in_IDEX_multicycle) ||
                                     ((state_r == BUSY) && (cnt_r != 4'd0)));
  assign raw_stall_s = !branch_s && (state_r == RUN) && !in_IDEX_multicycle && raw_s;

  // Control outputs: exactly one action per cycle, all quiet while reset is high.
  always_comb begin
    out_stall_PC    = 1'b0;
    out_stall_IFID  = 1'b0;
    out_stall_IDEX  = 1'b0;
    out_flush_IFID  = 1'b0;
    out_flush_IDEX  = 1'b0;
    out_flush_EXMEM = 1'b0;
    if (reset) begin
      out_stall_PC = 1'b0;
    end else if (branch_s) begin
      out_flush_IFID  = 1'b1;
      out_flush_IDEX  = 1'b1;
      out_flush_EXMEM = 1'b1;
    end else if (mc_stall_s) begin
      out_stall_PC    = 1'b1;
      out_stall_IFID  = 1'b1;
      out_stall_IDEX  = 1'b1;
      out_flush_EXMEM = 1'b1;
    end else if (raw_stall_s) begin
      out_stall_PC   = 1'b1;
      out_stall_IFID = 1'b1;
      out_flush_IDEX = 1'b1;
    end else begin
      out_stall_PC = 1'b0;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_r <= {CNT_W{1'b0}};
      flush_events_r <= {CNT_W{1'b0}};
    end else begin
      if (out_stall_PC && (stall_cycles_r != CNT_MAX)) begin
        stall_cycles_r <= stall_cycles_r + CNT_ONE;
      end
      if (out_flush_IFID && (flush_events_r != CNT_MAX)) begin
        flush_events_r <= flush_events_r + CNT_ONE;
      end
    end
  end

  assign out_stall_cycles = stall_cycles_r;
  assign out_flush_events = flush_events_r;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL: REG_ADDR_W, 5, register-index width.
REQ-002 SHALL: MUL_LATENCY, 4, EX occupancy in cycles of a multicycle op; legal range 2..16.
REQ-003 SHALL: CNT_W, 32, width of the performance counters.
REQ-004 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL: in_IFID_rs1/in_IFID_rs2  input  REG_ADDR_W  source registers of the instruction in decode.
REQ-007 SHALL: in_IFID_uses_rs1/in_IFID_uses_rs2  input  1  decode instruction actually reads rs1/rs2.
REQ-008 SHALL: in_IDEX_rd, in_EXMEM_rd, in_MEMWB_rd  input  REG_ADDR_W  destination registers per stage.
REQ-009 SHALL: in_IDEX_write_enable, in_EXMEM_write_enable, in_MEMWB_write_enable  input  1  stage writes rd.
REQ-010 SHALL: in_IDEX_mem_read  input  1  EX instruction is a load.
REQ-011 SHALL: in_IDEX_multicycle  input  1  EX instruction is a multicycle op.
REQ-012 SHALL: in_EXMEM_branch_taken  input  1  taken branch/jump resolved in MEM.
REQ-013 SHALL: out_stall_PC, out_stall_IFID, out_stall_IDEX  output  1  hold that register (combinational).
REQ-014 SHALL: out_flush_IFID, out_flush_IDEX, out_flush_EXMEM  output  1  load bubble into that register (combinational).
REQ-015 SHALL: out_stall_cycles, out_flush_events  output  CNT_W  registered performance counters.

Function
REQ-016 SHALL: a match requires rd != 0, the stage's write_enable = 1, and rd equal to a used IFID source; rd = 0 never matches.
REQ-017 SHALL: states RUN and BUSY, plus 4-bit down-counter cnt.
REQ-018 SHALL: priority is branch flush > multicycle stall > RAW stall; exactly one action per cycle.
REQ-019 SHALL: branch (in_EXMEM_branch_taken=1): flush_IFID=flush_IDEX=flush_EXMEM=1, all stalls 0, next state RUN, cnt<=0, even mid-BUSY.
REQ-020 SHALL: RUN with in_IDEX_multicycle=1: stall_PC=stall_IFID=stall_IDEX=1, flush_EXMEM=1, cnt<=MUL_LATENCY-2, next BUSY.
REQ-021 SHALL: BUSY with cnt!=0: same outputs as REQ-020, cnt<=cnt-1; BUSY with cnt==0: no stall, next RUN; total stall = MUL_LATENCY-1 cycles.
REQ-022 SHALL: RAW stall: stall_PC=stall_IFID=1, flush_IDEX=1 (bubble), for one cycle per detection; re-evaluated each cycle.
REQ-023 SHALL: in BUSY, RAW detection is ignored (pipeline already frozen).
REQ-024 SHALL: out_stall_cycles increments on every cycle out_stall_PC=1; out_flush_events increments on every cycle branch flush fires; both saturate at all-ones.
REQ-025 SHALL: with no hazard all six control outputs are 0.

Reset
REQ-026 SHALL: reset=1 forces state RUN, cnt=0, both counters 0, and all six control outputs 0 in the same cycle, overriding any input, including mid-BUSY.

Configuration
REQ-027 SHALL: macro HAZARD_FORWARDING_EN defined: RAW stall only on load-use (IDEX match with in_IDEX_mem_read=1); EXMEM/MEMWB matches are ignored (forwarded in EX).
REQ-028 SHALL: macro undefined: RAW stall on any match against IDEX, EXMEM or MEMWB rd (register file has no write-through); stall persists until no match remains.

Verification
REQ-029 SHALL: IDEX lw rd=5, mem_read=1; IFID uses rs1=5 -> one cycle stall_PC=stall_IFID=flush_IDEX=1, out_stall_cycles=1.
REQ-030 SHALL: IFID rs2=0, IDEX rd=0 write_enable=1, either config -> no stall.
REQ-031 SHALL: MUL_LATENCY=4, in_IDEX_multicycle=1 held -> stall_PC=1 for exactly 3 cycles, 4th cycle 0, state back to RUN.
REQ-032 SHALL: branch_taken=1 on 2nd BUSY cycle -> all three flushes 1, stalls 0, next cycle RUN, out_flush_events=1.
REQ-033 SHALL: undefined HAZARD_FORWARDING_EN, add x3 in IDEX, IFID reads x3 -> stall 3 cycles as producer drains IDEX->EXMEM->MEMWB; defined -> 0 cycles.
REQ-034 SHALL: reset=1 during BUSY with cnt=1 -> outputs 0 that cycle, counters 0 after edge, RUN.
